// File: rtl/reg_ul_mst_pkg.sv
// Shared constants for reg_ul_mst: FSM state encoding, latency counter width
// and the legal read-latency range checked at elaboration.
package reg_ul_mst_pkg;

  localparam int STATE_W    = 3;
  localparam int CNT_W      = 4;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RWAIT = 3'd3,
    ST_VRD   = 3'd4,
    ST_VWAIT = 3'd5,
    ST_RSP   = 3'd6
  } state_t;

  // The strobe cycle itself accounts for one edge of the read latency.
  function automatic logic [CNT_W-1:0] lat_load(input int rd_lat);
    return CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/reg_ul_mst_lat_cnt.sv
// Loadable down-counter that times the wait between a read strobe and the
// cycle whose closing edge samples the register file's read data.
module reg_ul_mst_lat_cnt
  import reg_ul_mst_pkg::*;
(
  input  logic             clks,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // High in the final wait cycle: the edge closing it brings the count to zero.
  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/reg_ul_mst.sv
// Single-outstanding register-bus initiator for the UL CPU register interface.
// Define REG_UL_MST_WR_VERIFY_EN to add masked read-back verification of writes.
module reg_ul_mst
  import reg_ul_mst_pkg::*;
#(
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int RD_LAT         = 2
) (
  input  logic                      clks,
  input  logic                      reset,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic                      req_wr,
  input  logic [CPU_ADDR_WIDTH-1:0] req_addr,
  input  logic [CPU_DATA_WIDTH-1:0] req_wdata,
  input  logic [CPU_DATA_WIDTH-1:0] req_vmask,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [CPU_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      cpu_wr,
  output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
  output logic                      cpu_rd,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
  output logic                      busy
);

  if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
    $error("reg_ul_mst: RD_LAT must lie in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(RD_LAT);

  state_t state;
  state_t state_nxt;
  logic   rdy_en;
  logic   accept;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_done;
  logic   capture;

`ifdef REG_UL_MST_WR_VERIFY_EN
  logic [CPU_DATA_WIDTH-1:0] vmask_q;
`else
  logic unused_vmask;
  assign unused_vmask = ^req_vmask;
`endif

  assign accept = req_vld && req_rdy;

  reg_ul_mst_lat_cnt u_lat_cnt (
    .clks     (clks),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // Holds req_rdy low through reset and until the first edge after release.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    capture   = 1'b0;
    req_rdy   = 1'b0;
    rsp_vld   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_rd    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy    = 1'b0;
        req_rdy = rdy_en;
        if (req_vld && rdy_en) begin
          state_nxt = req_wr ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        cpu_wr = 1'b1;
`ifdef REG_UL_MST_WR_VERIFY_EN
        state_nxt = (vmask_q != '0) ? ST_VRD : ST_RSP;
`else
        state_nxt = ST_RSP;
`endif
      end
      ST_RD: begin
        cpu_rd   = 1'b1;
        cnt_load = 1'b1;
        // A one-edge latency samples on the edge that leaves the strobe cycle.
        if (RD_LAT == 1) begin
          capture   = 1'b1;
          state_nxt = ST_RSP;
        end else begin
          state_nxt = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          capture   = 1'b1;
          state_nxt = ST_RSP;
        end
      end
`ifdef REG_UL_MST_WR_VERIFY_EN
      ST_VRD: begin
        cpu_rd   = 1'b1;
        cnt_load = 1'b1;
        if (RD_LAT == 1) begin
          capture   = 1'b1;
          state_nxt = ST_RSP;
        end else begin
          state_nxt = ST_VWAIT;
        end
      end
      ST_VWAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          capture   = 1'b1;
          state_nxt = ST_RSP;
        end
      end
`endif
      ST_RSP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus address/data stay registered after the access so the responder sees a stable address.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      cpu_wr_addr <= '0;
      cpu_data_in <= '0;
      rsp_rdata   <= '0;
    end else if (accept) begin
      cpu_wr_addr <= req_addr;
      rsp_rdata   <= '0;
      if (req_wr) begin
        cpu_data_in <= req_wdata;
      end
    end else if (capture) begin
      rsp_rdata <= cpu_data_out;
    end
  end

`ifdef REG_UL_MST_WR_VERIFY_EN
  // cpu_data_in still holds the written value when the read-back lands.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      vmask_q <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      vmask_q <= req_wr ? req_vmask : '0;
      rsp_err <= 1'b0;
    end else if (capture && ((state == ST_VRD) || (state == ST_VWAIT))) begin
      rsp_err <= |((cpu_data_out ^ cpu_data_in) & vmask_q);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_ul_mst.sv
// Directed bench for reg_ul_mst: writes, reads, response stall, write verify,
// reset abort, and a second instance built with a five-edge read latency.
module tb_reg_ul_mst;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clks = 1'b0;
  logic          reset = 1'b1;
  logic          req_vld;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_vmask;
  logic          rsp_rdy;

  logic          req_rdy;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          cpu_wr;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_data_in;
  logic          cpu_rd;
  logic [DW-1:0] cpu_data_out;
  logic          busy;

  logic          req_vld5;
  logic          rsp_rdy5;
  logic          req_rdy5;
  logic          rsp_vld5;
  logic [DW-1:0] rsp_rdata5;
  logic          rsp_err5;
  logic          cpu_wr5;
  logic [AW-1:0] cpu_wr_addr5;
  logic [DW-1:0] cpu_data_in5;
  logic          cpu_rd5;
  logic          busy5;

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] resp_q;
  logic [DW-1:0] data_cnt;
  logic [DW-1:0] snap;

  int checks = 0;
  int errors = 0;

  always #5 clks = ~clks;

  reg_ul_mst #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .RD_LAT(2)) dut (
    .clks(clks), .reset(reset),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_vmask(req_vmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_data_out(cpu_data_out), .busy(busy)
  );

  reg_ul_mst #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .RD_LAT(5)) dut5 (
    .clks(clks), .reset(reset),
    .req_vld(req_vld5), .req_rdy(req_rdy5), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_vmask(req_vmask),
    .rsp_vld(rsp_vld5), .rsp_rdy(rsp_rdy5), .rsp_rdata(rsp_rdata5), .rsp_err(rsp_err5),
    .cpu_wr(cpu_wr5), .cpu_wr_addr(cpu_wr_addr5), .cpu_data_in(cpu_data_in5),
    .cpu_rd(cpu_rd5), .cpu_data_out(data_cnt), .busy(busy5)
  );

  // Responder with registered read data; bit 0 of address 0x006 is stuck at zero.
  always @(posedge clks) begin
    if (reset) begin
      mem[12'h010] <= 32'hA5A5_1234;
    end else if (cpu_wr) begin
      mem[cpu_wr_addr] <= (cpu_wr_addr == 12'h006) ? (cpu_data_in & ~32'h1) : cpu_data_in;
    end
    if (reset) begin
      resp_q <= '0;
    end else if (cpu_rd) begin
      resp_q <= mem[cpu_wr_addr];
    end
  end
  assign cpu_data_out = resp_q;

  // Value changes every edge so the long-latency instance reveals its exact sampling edge.
  always @(posedge clks) begin
    if (reset) begin
      data_cnt <= 32'h0000_0100;
    end else begin
      data_cnt <= data_cnt + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clks);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic check_word(input string tag, input logic [DW-1:0] observed,
                            input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  initial begin
    req_vld   = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_vmask = '0;
    rsp_rdy   = 1'b1;
    req_vld5  = 1'b0;
    rsp_rdy5  = 1'b1;
    reset     = 1'b1;
    repeat (3) tick();

    check_bit("rst_req_rdy", req_rdy, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_rsp_vld", rsp_vld, 1'b0);
    check_bit("rst_cpu_wr", cpu_wr, 1'b0);
    check_bit("rst_cpu_rd", cpu_rd, 1'b0);
    check_word("rst_addr", 32'(cpu_wr_addr), 32'h0);
    check_word("rst_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    tick();
    check_bit("idle_req_rdy", req_rdy, 1'b1);

    $display("[TB] plain write 0x002 = 0x5");
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 12'h002; req_wdata = 32'h5; req_vmask = '0;
    tick();
    req_vld = 1'b0;
    check_bit("wr_strobe", cpu_wr, 1'b1);
    check_word("wr_addr", 32'(cpu_wr_addr), 32'h002);
    check_word("wr_data", cpu_data_in, 32'h5);
    check_bit("wr_req_rdy", req_rdy, 1'b0);
    check_bit("wr_busy", busy, 1'b1);
    check_bit("wr_rsp_early", rsp_vld, 1'b0);
    tick();
    check_bit("wr_strobe_one", cpu_wr, 1'b0);
    check_bit("wr_rsp_vld", rsp_vld, 1'b1);
    check_word("wr_rsp_rdata", rsp_rdata, 32'h0);
    check_bit("wr_rsp_err", rsp_err, 1'b0);
    tick();
    check_bit("wr_rsp_done", rsp_vld, 1'b0);
    check_bit("wr_idle_rdy", req_rdy, 1'b1);

    $display("[TB] read 0x010");
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h010;
    tick();
    req_vld = 1'b0;
    check_bit("rd_strobe", cpu_rd, 1'b1);
    check_word("rd_addr_t1", 32'(cpu_wr_addr), 32'h010);
    check_bit("rd_rsp_t1", rsp_vld, 1'b0);
    tick();
    check_bit("rd_strobe_one", cpu_rd, 1'b0);
    check_bit("rd_rsp_t2", rsp_vld, 1'b0);
    check_word("rd_addr_t2", 32'(cpu_wr_addr), 32'h010);
    tick();
    check_bit("rd_rsp_t3", rsp_vld, 1'b1);
    check_word("rd_rdata", rsp_rdata, 32'hA5A5_1234);
    check_bit("rd_err", rsp_err, 1'b0);
    check_word("rd_addr_t3", 32'(cpu_wr_addr), 32'h010);
    tick();

    $display("[TB] read 0x010 with response stalled, write waiting");
    rsp_rdy = 1'b0; req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h010;
    tick();
    req_wr = 1'b1; req_addr = 12'h020; req_wdata = 32'hDEAD_BEEF;
    check_bit("stall_req_rdy_rd", req_rdy, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check_bit("stall_rsp_vld", rsp_vld, 1'b1);
      check_word("stall_rdata", rsp_rdata, 32'hA5A5_1234);
      check_bit("stall_req_rdy", req_rdy, 1'b0);
      check_bit("stall_cpu_rd", cpu_rd, 1'b0);
      check_bit("stall_cpu_wr", cpu_wr, 1'b0);
      tick();
    end
    rsp_rdy = 1'b1;
    check_bit("stall_still_vld", rsp_vld, 1'b1);
    tick();
    check_bit("stall_done_vld", rsp_vld, 1'b0);
    check_bit("stall_resume_rdy", req_rdy, 1'b1);
    check_bit("stall_no_early_wr", cpu_wr, 1'b0);
    tick();
    req_vld = 1'b0;
    check_bit("stall_wr_strobe", cpu_wr, 1'b1);
    check_word("stall_wr_addr", 32'(cpu_wr_addr), 32'h020);
    check_word("stall_wr_data", cpu_data_in, 32'hDEAD_BEEF);
    tick();
    check_word("stall_wr_rdata", rsp_rdata, 32'h0);
    tick();

`ifdef REG_UL_MST_WR_VERIFY_EN
    $display("[TB] verify write 0x006 = 0xFFFF, mask 0xFFFF");
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 12'h006; req_wdata = 32'h0000_FFFF;
    req_vmask = 32'h0000_FFFF;
    tick();
    req_vld = 1'b0;
    check_bit("vfy_wr_strobe", cpu_wr, 1'b1);
    tick();
    check_bit("vfy_rd_strobe", cpu_rd, 1'b1);
    check_bit("vfy_wr_one", cpu_wr, 1'b0);
    check_bit("vfy_rsp_t2", rsp_vld, 1'b0);
    tick();
    check_bit("vfy_rsp_t3", rsp_vld, 1'b0);
    tick();
    check_bit("vfy_rsp_vld", rsp_vld, 1'b1);
    check_word("vfy_rdata", rsp_rdata, 32'h0000_FFFE);
    check_bit("vfy_err", rsp_err, 1'b1);
    tick();

    $display("[TB] verify write 0x006 = 0xFFFF, mask 0xFFFE");
    req_vld = 1'b1; req_vmask = 32'h0000_FFFE;
    tick();
    req_vld = 1'b0;
    repeat (3) tick();
    check_bit("vfy2_rsp_vld", rsp_vld, 1'b1);
    check_word("vfy2_rdata", rsp_rdata, 32'h0000_FFFE);
    check_bit("vfy2_err", rsp_err, 1'b0);
    tick();
`else
    $display("[TB] write 0x006 with mask, no verify");
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 12'h006; req_wdata = 32'h0000_FFFF;
    req_vmask = 32'h0000_FFFF;
    tick();
    req_vld = 1'b0;
    check_bit("nv_wr_strobe", cpu_wr, 1'b1);
    tick();
    check_bit("nv_rsp_vld", rsp_vld, 1'b1);
    check_bit("nv_no_rd", cpu_rd, 1'b0);
    check_word("nv_rdata", rsp_rdata, 32'h0);
    check_bit("nv_err", rsp_err, 1'b0);
    tick();
`endif
    req_vmask = '0;

    $display("[TB] reset during read wait");
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h010;
    tick();
    req_vld = 1'b0;
    tick();
    check_bit("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("abort_req_rdy", req_rdy, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_rsp_vld", rsp_vld, 1'b0);
    check_bit("abort_cpu_rd", cpu_rd, 1'b0);
    check_bit("abort_cpu_wr", cpu_wr, 1'b0);
    check_word("abort_addr", 32'(cpu_wr_addr), 32'h0);
    check_word("abort_rdata", rsp_rdata, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_bit("post_rst_rsp", rsp_vld, 1'b0);
    check_bit("post_rst_rd", cpu_rd, 1'b0);
    check_bit("post_rst_rdy", req_rdy, 1'b1);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h010;
    tick();
    req_vld = 1'b0;
    tick();
    tick();
    check_bit("post_rst_rd_vld", rsp_vld, 1'b1);
    check_word("post_rst_rdata", rsp_rdata, 32'hA5A5_1234);
    tick();

    $display("[TB] RD_LAT=5 instance read");
    req_vld5 = 1'b1; req_wr = 1'b0; req_addr = 12'h010;
    check_bit("lat5_req_rdy", req_rdy5, 1'b1);
    tick();
    req_vld5 = 1'b0;
    snap = data_cnt;
    check_bit("lat5_strobe", cpu_rd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("lat5_wait", rsp_vld5, 1'b0);
    end
    tick();
    check_bit("lat5_rsp_vld", rsp_vld5, 1'b1);
    check_word("lat5_rdata", rsp_rdata5, snap + 32'd4);
    tick();
    check_bit("lat5_done", rsp_vld5, 1'b0);
    check_bit("lat5_busy", busy5, 1'b0);
    check_word("lat5_addr", 32'(cpu_wr_addr5), 32'h010);
    check_bit("lat5_no_wr", cpu_wr5, 1'b0);
    check_bit("lat5_err", rsp_err5, 1'b0);
    check_word("lat5_data_in", cpu_data_in5, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
